// File: rtl/obi_pkg.sv
// Shared types and constants for the OBI two-requester arbiter.
package obi_pkg;

    localparam int OBI_AW = 32;
    localparam int OBI_DW = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_RESP
    } obi_arb_state_e;

endpackage

// File: rtl/obi_rr_picker.sv
// Two-way round-robin picker; a held lock overrides fairness until the locked request is granted.
module obi_rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       lock,
    input  logic       locked_id,
    output logic       winner,
    output logic       valid
);

    // A locked requester that drops its request yields no winner this cycle.
    always_comb begin
        winner = 1'b0;
        valid  = 1'b0;
        if (lock) begin
            winner = locked_id;
            valid  = req[locked_id];
        end else begin
            valid = |req;
            if (req == 2'b11) begin
                winner = ~last;
            end else begin
                winner = req[1];
            end
        end
    end

endmodule

// File: rtl/obi_arbiter.sv
// Arbitrates two OBI requesters onto one subordinate with at most one outstanding transaction.
module obi_arbiter
    import obi_pkg::*;
#(
    parameter int AW = OBI_AW,
    parameter int DW = OBI_DW
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            m0_req_i,
    output logic            m0_gnt_o,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_be_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,

    input  logic            m1_req_i,
    output logic            m1_gnt_o,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_be_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,

    output logic            s_req_o,
    output logic [AW-1:0]   s_addr_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_be_o,
    output logic [DW-1:0]   s_wdata_o,
    input  logic            s_gnt_i,
    input  logic            s_rvalid_i,
    input  logic [DW-1:0]   s_rdata_i
);

    obi_arb_state_e state_q, state_d;
    logic owner_q, owner_d;
    logic last_q, last_d;
    logic lock_q, lock_d;
    logic locked_id_q, locked_id_d;

    logic winner;
    logic win_valid;
    logic accept;

    obi_rr_picker u_picker (
        .req       ({m1_req_i, m0_req_i}),
        .last      (last_q),
        .lock      (lock_q),
        .locked_id (locked_id_q),
        .winner    (winner),
        .valid     (win_valid)
    );

    assign s_addr_o  = winner ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = winner ? m1_we_i    : m0_we_i;
    assign s_be_o    = winner ? m1_be_i    : m0_be_i;
    assign s_wdata_o = winner ? m1_wdata_i : m0_wdata_i;

    assign accept = s_req_o & s_gnt_i;

    assign m0_gnt_o = accept & ~winner;
    assign m1_gnt_o = accept & winner;

    assign m0_rvalid_o = s_rvalid_i & ~rst_i & (state_q == ARB_RESP) & ~owner_q;
    assign m1_rvalid_o = s_rvalid_i & ~rst_i & (state_q == ARB_RESP) & owner_q;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;

    // While a response is outstanding a new request may only overlap the rvalid cycle.
    always_comb begin
        s_req_o     = 1'b0;
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        lock_d      = 1'b0;
        locked_id_d = locked_id_q;

        if (!rst_i) begin
            unique case (state_q)
                ARB_IDLE: s_req_o = win_valid;
                ARB_RESP: s_req_o = s_rvalid_i & win_valid;
                default:  s_req_o = 1'b0;
            endcase
        end

        if (accept) begin
            state_d = ARB_RESP;
            owner_d = winner;
            last_d  = winner;
        end else if (state_q == ARB_RESP && s_rvalid_i) begin
            state_d = ARB_IDLE;
        end

        if (s_req_o && !s_gnt_i) begin
            lock_d      = 1'b1;
            locked_id_d = winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            locked_id_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
        end
    end

endmodule

// File: tb/tb_obi_arbiter.sv
// Directed and randomized check of obi_arbiter against a transaction-level reference model.
module tb_obi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst;
    logic            m0_req, m1_req;
    logic            m0_gnt, m1_gnt;
    logic [AW-1:0]   m0_addr, m1_addr;
    logic            m0_we, m1_we;
    logic [DW/8-1:0] m0_be, m1_be;
    logic [DW-1:0]   m0_wdata, m1_wdata;
    logic            m0_rvalid, m1_rvalid;
    logic [DW-1:0]   m0_rdata, m1_rdata;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_we;
    logic [DW/8-1:0] s_be;
    logic [DW-1:0]   s_wdata;
    logic            s_gnt, s_rvalid;
    logic [DW-1:0]   s_rdata;

    int tests = 0;
    int fails = 0;

    // Reference model: who holds the outstanding response (-1 none), last winner, locked requester (-1 none).
    int mPending = -1;
    int mLast    = 1;
    int mLock    = -1;
    int expWinner;
    logic expSreq;

    obi_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_req_i    (m0_req),
        .m0_gnt_o    (m0_gnt),
        .m0_addr_i   (m0_addr),
        .m0_we_i     (m0_we),
        .m0_be_i     (m0_be),
        .m0_wdata_i  (m0_wdata),
        .m0_rvalid_o (m0_rvalid),
        .m0_rdata_o  (m0_rdata),
        .m1_req_i    (m1_req),
        .m1_gnt_o    (m1_gnt),
        .m1_addr_i   (m1_addr),
        .m1_we_i     (m1_we),
        .m1_be_i     (m1_be),
        .m1_wdata_i  (m1_wdata),
        .m1_rvalid_o (m1_rvalid),
        .m1_rdata_o  (m1_rdata),
        .s_req_o     (s_req),
        .s_addr_o    (s_addr),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_wdata_o   (s_wdata),
        .s_gnt_i     (s_gnt),
        .s_rvalid_i  (s_rvalid),
        .s_rdata_i   (s_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one cycle of inputs with fresh random payload, then lets combinational outputs settle.
    task automatic applyStimulus(input logic r, input logic q0, input logic q1,
                                 input logic g, input logic rv,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] rd);
        rst      = r;
        m0_req   = q0;
        m1_req   = q1;
        s_gnt    = g;
        s_rvalid = rv;
        m0_addr  = a0;
        m1_addr  = a1;
        m0_we    = 1'($urandom);
        m1_we    = 1'($urandom);
        m0_be    = 4'($urandom);
        m1_be    = 4'($urandom);
        m0_wdata = $urandom;
        m1_wdata = $urandom;
        s_rdata  = rd;
        #1;
    endtask

    task automatic modelEval();
        if (mLock >= 0) begin
            expWinner = (mLock == 0 ? m0_req : m1_req) ? mLock : -1;
        end else if (m0_req && m1_req) begin
            expWinner = 1 - mLast;
        end else if (m0_req) begin
            expWinner = 0;
        end else if (m1_req) begin
            expWinner = 1;
        end else begin
            expWinner = -1;
        end
        expSreq = !rst && expWinner >= 0 && (mPending < 0 || s_rvalid);
    endtask

    task automatic checkOutput();
        modelEval();
        checkValue("s_req", 32'(s_req), 32'(expSreq));
        checkValue("m0_gnt", 32'(m0_gnt), 32'(expSreq && s_gnt && expWinner == 0));
        checkValue("m1_gnt", 32'(m1_gnt), 32'(expSreq && s_gnt && expWinner == 1));
        checkValue("m0_rvalid", 32'(m0_rvalid), 32'(s_rvalid && !rst && mPending == 0));
        checkValue("m1_rvalid", 32'(m1_rvalid), 32'(s_rvalid && !rst && mPending == 1));
        checkValue("m0_rdata", m0_rdata, s_rdata);
        checkValue("m1_rdata", m1_rdata, s_rdata);
        if (expSreq) begin
            checkValue("s_addr", s_addr, expWinner == 1 ? m1_addr : m0_addr);
            checkValue("s_we", 32'(s_we), 32'(expWinner == 1 ? m1_we : m0_we));
            checkValue("s_be", 32'(s_be), 32'(expWinner == 1 ? m1_be : m0_be));
            checkValue("s_wdata", s_wdata, expWinner == 1 ? m1_wdata : m0_wdata);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mPending = -1;
            mLast    = 1;
            mLock    = -1;
        end else begin
            if (mPending >= 0 && s_rvalid) mPending = -1;
            if (expSreq && s_gnt) begin
                mPending = expWinner;
                mLast    = expWinner;
            end
            mLock = (expSreq && !s_gnt) ? expWinner : -1;
        end
        #1;
    endtask

    task automatic step(input logic r, input logic q0, input logic q1,
                        input logic g, input logic rv);
        applyStimulus(r, q0, q1, g, rv, $urandom, $urandom, $urandom);
        checkOutput();
        tick();
    endtask

    task automatic doReset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        @(posedge clk);
        #1;
        doReset();
        checkValue("reset_s_req", 32'(s_req), 32'd0);

        // Single read by m0 with immediate grant and response one cycle later.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 0);
        checkOutput();
        checkValue("r031_m0_gnt", 32'(m0_gnt), 32'd1);
        checkValue("r031_addr", s_addr, 32'h100);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 32'hDEADBEEF);
        checkOutput();
        checkValue("r031_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkValue("r031_m0_rdata", m0_rdata, 32'hDEADBEEF);
        checkValue("r031_m1_rvalid", 32'(m1_rvalid), 32'd0);
        tick();

        // Simultaneous requests alternate starting with m0.
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 0);
            checkOutput();
            checkValue("r032_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
            checkValue("r032_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
            tick();
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Withheld grant keeps m1 locked even though m0 joins.
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200, 0);
        checkOutput();
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h300, 32'h200, 0);
            checkOutput();
            checkValue("r033_addr", s_addr, 32'h200);
            checkValue("r033_m0_gnt", 32'(m0_gnt), 32'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h200, 0);
        checkOutput();
        checkValue("r033_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back: m1 granted on m0's response cycle.
        doReset();
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, $urandom, $urandom, $urandom);
        checkOutput();
        checkValue("r034_m0_rvalid", 32'(m0_rvalid), 32'd1);
        checkValue("r034_m1_gnt", 32'(m1_gnt), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, $urandom);
        checkOutput();
        checkValue("r034_m1_rvalid", 32'(m1_rvalid), 32'd1);
        checkValue("r034_m0_rvalid", 32'(m0_rvalid), 32'd0);
        tick();

        // Reset abandons the outstanding response and restores m0 priority.
        doReset();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, $urandom);
        checkOutput();
        checkValue("r035_m0_rvalid", 32'(m0_rvalid), 32'd0);
        checkValue("r035_m1_rvalid", 32'(m1_rvalid), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, $urandom, $urandom, 0);
        checkOutput();
        checkValue("r035_tie_m0", 32'(m0_gnt), 32'd1);
        tick();

        // Pending request must wait while the response is outstanding.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, $urandom, $urandom, 0);
            checkOutput();
            checkValue("r036_s_req", 32'(s_req), 32'd0);
            tick();
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Locked requester withdrawing: lock clears and the other side may win next.
        doReset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic, including dropped responses in idle and occasional resets.
        doReset();
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
